// File: rtl/data_cache_controller.sv
// data_cache_controller
//   Direct-mapped, write-back, write-allocate data cache for the memory stage.
//   16 lines x one 32-bit word; tag = addr[31:6], index = addr[5:2].
//   Hits complete with zero stall. Misses write back a dirty victim (if any)
//   and then fill the line over a single-outstanding req/ack memory port.
//   Per-line flush writes back a dirty line and invalidates it.
//
// Ports
//   iClk, iRst          clock, synchronous active-high reset
//   iTag, iIndex        tag / line index of the current access
//   iIndexFlush, iFlush line index to flush, flush request
//   iReadEn, iWriteEn   load / store request (both high = store)
//   iWriteData          store data
//   oReadData           load data, valid when iReadEn=1 and oStall=0
//   oStall              access or flush cannot complete this cycle
//   oMemReq, oMemWe     memory request (held until ack), 1 = write-back
//   oMemAddr, oMemWData word address (low bits 00) and write-back data
//   iMemAck, iMemRData  one-cycle acknowledge and fill data
module data_cache_controller (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [25:0] iTag,
  input  logic [3:0]  iIndex,
  input  logic [3:0]  iIndexFlush,
  input  logic        iReadEn,
  input  logic        iWriteEn,
  input  logic [31:0] iWriteData,
  input  logic        iFlush,
  output logic [31:0] oReadData,
  output logic        oStall,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData
);

  localparam int LINES  = 16;
  localparam int TAG_W  = 26;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    FLUSH_WB  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];

  logic access;
  logic hit;
  logic victim_dirty;
  logic flush_dirty;
  logic is_idle;
  logic flush_clean_evt;
  logic write_hit_evt;
  logic fill_evt;
  logic flush_done_evt;

  assign access       = iReadEn | iWriteEn;
  assign hit          = valid[iIndex] && (tags[iIndex] == iTag);
  assign victim_dirty = valid[iIndex] & dirty[iIndex];
  assign flush_dirty  = valid[iIndexFlush] & dirty[iIndexFlush];
  assign is_idle      = (state == IDLE);

  // A flush request owns the IDLE cycle; any access presented alongside it waits.
  assign flush_clean_evt = is_idle & iFlush & ~flush_dirty;
  assign write_hit_evt   = is_idle & ~iFlush & iWriteEn & hit;
  // iMemAck only matters in the request states, where oMemReq is always high.
  assign fill_evt        = (state == FILL) & iMemAck;
  assign flush_done_evt  = (state == FLUSH_WB) & iMemAck;

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (iFlush) begin
          if (flush_dirty) state_nxt = FLUSH_WB;
        end else if (access && !hit) begin
          state_nxt = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: if (iMemAck) state_nxt = FILL;
      FILL:      if (iMemAck) state_nxt = IDLE;
      FLUSH_WB:  if (iMemAck) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs. Memory address/data are derived from the held core inputs and
  // from line state that does not change until the ack, so they stay stable
  // for the whole request.
  always_comb begin
    oReadData = '0;
    oStall    = 1'b1;
    oMemReq   = 1'b0;
    oMemWe    = 1'b0;
    oMemAddr  = '0;
    oMemWData = '0;
    case (state)
      IDLE: begin
        if (iFlush) begin
          oStall = flush_dirty | access;
        end else begin
          oStall = access & ~hit;
          if (iReadEn && hit) oReadData = data[iIndex];
        end
      end
      WRITEBACK: begin
        oMemReq   = 1'b1;
        oMemWe    = 1'b1;
        oMemAddr  = {tags[iIndex], iIndex, 2'b00};
        oMemWData = data[iIndex];
      end
      FILL: begin
        oMemReq  = 1'b1;
        oMemAddr = {iTag, iIndex, 2'b00};
      end
      FLUSH_WB: begin
        oMemReq   = 1'b1;
        oMemWe    = 1'b1;
        oMemAddr  = {tags[iIndexFlush], iIndexFlush, 2'b00};
        oMemWData = data[iIndexFlush];
      end
      default: ;
    endcase
  end

  // Line control bits
  always_ff @(posedge iClk) begin
    if (iRst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (flush_clean_evt) begin
        valid[iIndexFlush] <= 1'b0;
        dirty[iIndexFlush] <= 1'b0;
      end
      if (write_hit_evt) begin
        dirty[iIndex] <= 1'b1;
      end
      if (fill_evt) begin
        valid[iIndex] <= 1'b1;
        dirty[iIndex] <= 1'b0;
      end
      if (flush_done_evt) begin
        valid[iIndexFlush] <= 1'b0;
        dirty[iIndexFlush] <= 1'b0;
      end
    end
  end

  // Tag and data arrays; meaningless while the valid bit is clear
  always_ff @(posedge iClk) begin
    if (write_hit_evt) begin
      data[iIndex] <= iWriteData;
    end
    if (fill_evt) begin
      data[iIndex] <= iMemRData;
      tags[iIndex] <= iTag;
    end
  end

endmodule
